mem_arbiter: RTL

Arbitrates the datapath's instruction-fetch and data-access streams onto a single-ported memory bus, one access at a time. Sits between the datapath cache interface and the RAM controller. Data requests take priority; an optional fairness guard bounds instruction starvation. A watchdog abandons accesses the RAM never completes.

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arbiter_if.sv | 43 ++++
 rtl/mem_arbiter_watchdog.sv | 34 +++
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared word and arbiter-state types for the memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } arb_state_t;

    localparam int c_STREAK_W = 4;
    localparam int c_WDOG_W   = 8;

endpackage : cpu_types_pkg

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module      : mem_arbiter_if
// Description : Cache-side request/response and RAM-side bus of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if;
    import cpu_types_pkg::*;

    logic  iREN;
    word_t iaddr;
    word_t iload;
    logic  ihit;
    logic  dREN;
    logic  dWEN;
    word_t daddr;
    word_t dstore;
    word_t dload;
    logic  dhit;
    logic  ramREN;
    logic  ramWEN;
    word_t ramaddr;
    word_t ramstore;
    word_t ramload;
    logic  ramrdy;
    logic  err;

    // Arbiter view
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramrdy,
        output iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, err
    );

    // Environment view: datapath requesters plus RAM controller
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramrdy,
        input  iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, err
    );

endinterface : mem_arbiter_if

`default_nettype wire

// File: rtl/mem_arbiter_watchdog.sv
// ============================================================================
// Module      : arb_watchdog
// Description : Counts cycles while active; pulses expire on the TIMEOUT-th.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_watchdog
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic active,
    output logic      expire
);

    logic [c_WDOG_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || !active) begin
            r_count <= '0;
        end else if (r_count != {c_WDOG_W{1'b1}}) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Fires during the TIMEOUT-th active cycle, i.e. as the count reaches TIMEOUT
    assign expire = active && (r_count == c_WDOG_W'(TIMEOUT - 1));

endmodule : arb_watchdog

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Data-priority arbiter of fetch/data streams onto one RAM port.
//               Define MEM_ARB_FAIR_EN to build the fetch-starvation guard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 255
) (
    input  wire logic      CLK,
    input  wire logic      RST,
    mem_arbiter_if.slave   bus
);

    if (MAX_DSTREAK < 1 || MAX_DSTREAK > 15) begin : g_bad_streak
        $error("mem_arbiter: MAX_DSTREAK out of range 1..15");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT out of range 1..255");
    end

    arb_state_t r_state;
    logic       r_write;
    word_t      r_addr;
    word_t      r_store;
    word_t      r_iload;
    word_t      r_dload;
    logic       r_ram_ren;
    logic       r_ram_wen;
    logic       r_ihit;
    logic       r_dhit;
    logic       r_err;
    logic       w_dreq;
    logic       w_trip;
    logic       w_active;
    logic       w_expire;

    assign w_dreq   = bus.dREN || bus.dWEN;
    assign w_active = (r_state != IDLE);

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (CLK),
        .rst    (RST),
        .active (w_active),
        .expire (w_expire)
    );

`ifdef MEM_ARB_FAIR_EN
    logic [c_STREAK_W-1:0] r_streak;

    assign w_trip = bus.iREN && (r_streak == c_STREAK_W'(MAX_DSTREAK));

    // Streak only moves on IDLE grants: bumped by data grants that pass over a fetch
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_streak <= '0;
        end else if (r_state == IDLE) begin
            if (w_dreq && !w_trip) begin
                r_streak <= bus.iREN ? r_streak + 1'b1 : '0;
            end else if (bus.iREN) begin
                r_streak <= '0;
            end
        end
    end
`else
    assign w_trip = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_store   <= '0;
            r_iload   <= '0;
            r_dload   <= '0;
            r_ram_ren <= 1'b0;
            r_ram_wen <= 1'b0;
            r_ihit    <= 1'b0;
            r_dhit    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_ihit <= 1'b0;
            r_dhit <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_dreq && !w_trip) begin
                        r_state   <= DACC;
                        r_addr    <= bus.daddr;
                        r_store   <= bus.dstore;
                        r_write   <= bus.dWEN;
                        r_ram_wen <= bus.dWEN;
                        r_ram_ren <= !bus.dWEN;
                    end else if (bus.iREN) begin
                        r_state   <= IACC;
                        r_addr    <= bus.iaddr;
                        r_ram_ren <= 1'b1;
                    end
                end
                IACC, DACC: begin
                    // A completion in the watchdog's final cycle still counts
                    if (bus.ramrdy) begin
                        if (r_state == IACC) begin
                            r_iload <= bus.ramload;
                            r_ihit  <= 1'b1;
                        end else begin
                            if (!r_write) begin
                                r_dload <= bus.ramload;
                            end
                            r_dhit <= 1'b1;
                        end
                        r_state   <= IDLE;
                        r_ram_ren <= 1'b0;
                        r_ram_wen <= 1'b0;
                    end else if (w_expire) begin
                        r_err     <= 1'b1;
                        r_state   <= IDLE;
                        r_ram_ren <= 1'b0;
                        r_ram_wen <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_ram_ren <= 1'b0;
                    r_ram_wen <= 1'b0;
                end
            endcase
        end
    end

    assign bus.iload    = r_iload;
    assign bus.ihit     = r_ihit;
    assign bus.dload    = r_dload;
    assign bus.dhit     = r_dhit;
    assign bus.ramREN   = r_ram_ren;
    assign bus.ramWEN   = r_ram_wen;
    assign bus.ramaddr  = r_addr;
    assign bus.ramstore = r_store;
    assign bus.err      = r_err;

endmodule : mem_arbiter

`default_nettype wire
